// File: rtl/cplx_pair_pipe_if.sv
// Handshake bundle for the complex-pair delay line: input pair, output pair,
// flush and occupancy. The pipe takes the slave side.
interface cplx_pair_pipe_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_re;
    logic [W-1:0]  a_img;
    logic [W-1:0]  b_re;
    logic [W-1:0]  b_img;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  a1_re;
    logic [W-1:0]  a1_img;
    logic [W-1:0]  b1_re;
    logic [W-1:0]  b1_img;
    logic [LW-1:0] level;

    modport master (
        output flush, in_valid, a_re, a_img, b_re, b_img, out_ready,
        input  in_ready, out_valid, a1_re, a1_img, b1_re, b1_img, level
    );

    modport slave (
        input  flush, in_valid, a_re, a_img, b_re, b_img, out_ready,
        output in_ready, out_valid, a1_re, a1_img, b1_re, b1_img, level
    );
endinterface

// File: rtl/cplx_pair_pipe.sv
// Elastic DEPTH-stage delay line for a complex pair (a, b) with valid/ready
// backpressure, bubble collapsing, synchronous flush and occupancy count.
module cplx_pair_pipe #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cplx_pair_pipe_if.slave pipe
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] a_re;
        logic [W-1:0] a_img;
        logic [W-1:0] b_re;
        logic [W-1:0] b_img;
    } pair_t;

    pair_t            data_q    [DEPTH];
    pair_t            up_data_c [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] en_c;
    logic [DEPTH-1:0] up_v_c;
    logic [DEPTH-1:0] ld_c;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;

    // Ready ripples from the output back: a stage advances when empty or when its successor advances.
    always_comb begin
        logic en_next;
        en_next = pipe.out_ready;
        en_c    = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            en_next = ~v_q[k] | en_next;
            en_c[k] = en_next;
        end
    end

    // What each stage would load: the input pair for stage 0, the previous stage otherwise.
    always_comb begin
        up_v_c = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            up_data_c[k] = '0;
        end
        up_v_c[0]    = pipe.in_valid & en_c[0] & ~pipe.flush;
        up_data_c[0] = {pipe.a_re, pipe.a_img, pipe.b_re, pipe.b_img};
        for (int k = 1; k < int'(DEPTH); k++) begin
            up_v_c[k]    = v_q[k-1];
            up_data_c[k] = data_q[k-1];
        end
    end

    // Next valid tags, data load strobes and post-edge population; flush empties every stage.
    always_comb begin
        v_d     = '0;
        ld_c    = '0;
        level_d = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (!pipe.flush) begin
                v_d[k]  = en_c[k] ? up_v_c[k] : v_q[k];
                ld_c[k] = en_c[k] & up_v_c[k];
            end
            level_d = level_d + LW'(v_d[k]);
        end
    end

    // Stage registers: tags always follow v_d, data only moves when a valid pair arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            level_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            level_q <= level_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (ld_c[k]) begin
                    data_q[k] <= up_data_c[k];
                end
            end
        end
    end

    assign pipe.in_ready  = en_c[0] & ~pipe.flush;
    assign pipe.out_valid = v_q[DEPTH-1];
    assign pipe.a1_re     = data_q[DEPTH-1].a_re;
    assign pipe.a1_img    = data_q[DEPTH-1].a_img;
    assign pipe.b1_re     = data_q[DEPTH-1].b_re;
    assign pipe.b1_img    = data_q[DEPTH-1].b_img;
    assign pipe.level     = level_q;
endmodule
